// File: rtl/coin_pulse_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Package : coin_pkg
// Brief   : Coin codes, emitter states and channel/code helpers.
// Rev     : 1.0 - initial release
// ============================================================================
package coin_pkg;

  localparam int c_NUM_CHANNELS = 3;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_5    = 2'd1,
    COIN_10   = 2'd2,
    COIN_25   = 2'd3
  } coin_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } emit_state_t;

  // Lowest-value coin wins: bit 0 = 5c, bit 1 = 10c, bit 2 = 25c.
  function automatic coin_code_t lowestPending(input logic [2:0] pending);
    coin_code_t code;
    code = COIN_NONE;
    if (pending[0]) begin
      code = COIN_5;
    end else if (pending[1]) begin
      code = COIN_10;
    end else if (pending[2]) begin
      code = COIN_25;
    end
    return code;
  endfunction

  function automatic logic [2:0] codeToOneHot(input coin_code_t code);
    logic [2:0] oneHot;
    case (code)
      COIN_5:  oneHot = 3'b001;
      COIN_10: oneHot = 3'b010;
      COIN_25: oneHot = 3'b100;
      default: oneHot = 3'b000;
    endcase
    return oneHot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_pulse_conditioner_if.sv
`default_nettype none
// ============================================================================
// Interface : coin_pulse_conditioner_if
// Brief     : Raw sensor inputs and conditioned coin pulses of the front end.
// Rev       : 1.0 - initial release
// ============================================================================
interface coin_pulse_conditioner_if #(
  parameter int QUEUE_DEPTH = 4
);
  localparam int c_COUNT_W = $clog2(QUEUE_DEPTH + 1);

  logic                 coinSense5;
  logic                 coinSense10;
  logic                 coinSense25;
  logic                 inhibit;
  logic                 fiveCents;
  logic                 tenCents;
  logic                 twentyFiveCents;
  logic                 coinRejected;
  logic                 coinDropped;
  logic [c_COUNT_W-1:0] queueCount;

  modport master (
    output coinSense5, coinSense10, coinSense25, inhibit,
    input  fiveCents, tenCents, twentyFiveCents, coinRejected, coinDropped, queueCount
  );

  modport slave (
    input  coinSense5, coinSense10, coinSense25, inhibit,
    output fiveCents, tenCents, twentyFiveCents, coinRejected, coinDropped, queueCount
  );
endinterface
`default_nettype wire

// File: rtl/coin_pulse_conditioner_debouncer.sv
`default_nettype none
// ============================================================================
// Module : coin_debouncer
// Brief  : Two-flop synchroniser, stability counter and debounced rise pulse.
// Rev    : 1.0 - initial release
// ============================================================================
module coin_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_rise
);
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic               r_stableDly;
  logic [c_CNT_W-1:0] r_count;

  // The toggle happens on the edge that would take the count to DEBOUNCE_CYCLES.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_stable    <= 1'b0;
      r_stableDly <= 1'b0;
      r_count     <= '0;
    end else begin
      r_sync1     <= i_raw;
      r_sync2     <= r_sync1;
      r_stableDly <= r_stable;
      if (r_sync2 == r_stable) begin
        r_count <= '0;
      end else if (r_count == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= ~r_stable;
        r_count  <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_rise = r_stable & ~r_stableDly;

endmodule
`default_nettype wire

// File: rtl/coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module : coin_pulse_conditioner
// Brief  : Debounces three coin sensors, queues coins, replays one-hot pulses.
// Rev    : 1.0 - initial release
// ============================================================================
module coin_pulse_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUEUE_DEPTH     = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  coin_pulse_conditioner_if.slave bus
);
  localparam int c_PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int c_COUNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [2:0] w_raw;
  logic [2:0] w_rise;

  assign w_raw = {bus.coinSense25, bus.coinSense10, bus.coinSense5};

  for (genvar g = 0; g < c_NUM_CHANNELS; g++) begin : g_chan
    coin_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock (clock),
      .reset (reset),
      .i_raw (w_raw[g]),
      .o_rise(w_rise[g])
    );
  end

  // Event capture and arbitration into the FIFO
  logic [2:0]           r_pending;
  logic [2:0]           w_accept;
  logic [2:0]           w_pushMask;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  coin_code_t           w_pushCode;
  coin_code_t           w_popCode;
  logic                 r_coinRejected;
  logic                 r_coinDropped;

  always_comb begin
    w_accept   = w_rise & {3{~bus.inhibit}};
    w_pushCode = lowestPending(r_pending);
    w_push     = (r_pending != 3'b000) && !w_full;
    w_pushMask = w_push ? codeToOneHot(w_pushCode) : 3'b000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending      <= 3'b000;
      r_coinRejected <= 1'b0;
      r_coinDropped  <= 1'b0;
    end else begin
      r_pending      <= (r_pending & ~w_pushMask) | (w_accept & ~r_pending);
      r_coinRejected <= bus.inhibit & (|w_rise);
      r_coinDropped  <= |(w_accept & r_pending);
    end
  end

  // Coin FIFO; storage needs no reset because occupancy gates every read.
  coin_code_t           r_mem [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [c_COUNT_W-1:0] r_count;

  assign w_full    = (r_count == c_COUNT_W'(QUEUE_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_popCode = r_mem[r_rdPtr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_pushCode;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Emitter: w_release marks a cycle in which the next coin may be taken.
  emit_state_t        r_state;
  emit_state_t        w_stateNext;
  logic [c_GAP_W-1:0] r_gapCount;
  logic [c_GAP_W-1:0] w_gapCountNext;
  logic [2:0]         r_coinOut;
  logic [2:0]         w_coinOutNext;
  logic               w_release;

  always_comb begin
    w_stateNext    = r_state;
    w_gapCountNext = r_gapCount;
    w_coinOutNext  = 3'b000;
    w_pop          = 1'b0;
    w_release      = 1'b0;
    case (r_state)
      IDLE: w_release = 1'b1;
      EMIT: begin
        if (GAP_CYCLES == 0) begin
          w_release = 1'b1;
        end else begin
          w_stateNext    = GAP;
          w_gapCountNext = '0;
        end
      end
      GAP: begin
        if (r_gapCount == c_GAP_W'(c_GAP_LAST)) begin
          w_release = 1'b1;
        end else begin
          w_gapCountNext = r_gapCount + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    if (w_release) begin
      if (!w_empty) begin
        w_pop         = 1'b1;
        w_coinOutNext = codeToOneHot(w_popCode);
        w_stateNext   = EMIT;
      end else begin
        w_stateNext = IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gapCount <= '0;
      r_coinOut  <= 3'b000;
    end else begin
      r_state    <= w_stateNext;
      r_gapCount <= w_gapCountNext;
      r_coinOut  <= w_coinOutNext;
    end
  end

  assign bus.fiveCents       = r_coinOut[0];
  assign bus.tenCents        = r_coinOut[1];
  assign bus.twentyFiveCents = r_coinOut[2];
  assign bus.coinRejected    = r_coinRejected;
  assign bus.coinDropped     = r_coinDropped;
  assign bus.queueCount      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module : tb_coin_pulse_conditioner
// Brief  : Directed and randomized checks of the coin pulse conditioner.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_coin_pulse_conditioner;
  localparam int TB_DEBOUNCE = 16;
  localparam int RAND_ACTIVE = 10000;
  localparam int RAND_LEN    = 10300;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  coin_pulse_conditioner_if #(.QUEUE_DEPTH(4)) busA ();
  coin_pulse_conditioner_if #(.QUEUE_DEPTH(2)) busB ();

  coin_pulse_conditioner #(
    .DEBOUNCE_CYCLES(TB_DEBOUNCE), .QUEUE_DEPTH(4), .GAP_CYCLES(1)
  ) dutA (
    .clock(clock), .reset(reset), .bus(busA)
  );

  coin_pulse_conditioner #(
    .DEBOUNCE_CYCLES(1), .QUEUE_DEPTH(2), .GAP_CYCLES(100)
  ) dutB (
    .clock(clock), .reset(reset), .bus(busB)
  );

  int checks = 0;
  int errors = 0;
  int edgeIdx = 0;
  int nA5, nA10, nA25, nArej, nAdrop;
  int firstA5, firstA10, firstA25, firstArej;
  int nB, nB5, nBdrop, lastB, minSpB, maxSpB, maxQB;
  int e0;

  bit rawH [3][RAND_LEN];
  bit inhH [RAND_LEN];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    nA5 = 0; nA10 = 0; nA25 = 0; nArej = 0; nAdrop = 0;
    firstA5 = -1; firstA10 = -1; firstA25 = -1; firstArej = -1;
    nB = 0; nB5 = 0; nBdrop = 0; lastB = -1; minSpB = 1000000; maxSpB = 0; maxQB = 0;
  endtask

  task automatic sample();
    int sp;
    check("onehotA", int'($countones({busA.fiveCents, busA.tenCents, busA.twentyFiveCents}) <= 1), 1);
    check("onehotB", int'($countones({busB.fiveCents, busB.tenCents, busB.twentyFiveCents}) <= 1), 1);
    check("queueBoundA", int'(int'(busA.queueCount) <= 4), 1);
    if (busA.fiveCents) begin nA5++; if (firstA5 < 0) firstA5 = edgeIdx; end
    if (busA.tenCents) begin nA10++; if (firstA10 < 0) firstA10 = edgeIdx; end
    if (busA.twentyFiveCents) begin nA25++; if (firstA25 < 0) firstA25 = edgeIdx; end
    if (busA.coinRejected) begin nArej++; if (firstArej < 0) firstArej = edgeIdx; end
    if (busA.coinDropped) nAdrop++;
    if (busB.fiveCents | busB.tenCents | busB.twentyFiveCents) begin
      nB++;
      if (lastB >= 0) begin
        sp = edgeIdx - lastB;
        if (sp < minSpB) minSpB = sp;
        if (sp > maxSpB) maxSpB = sp;
      end
      lastB = edgeIdx;
    end
    if (busB.fiveCents) nB5++;
    if (busB.coinDropped) nBdrop++;
    if (int'(busB.queueCount) > maxQB) maxQB = int'(busB.queueCount);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edgeIdx++;
    sample();
  endtask

  initial begin
    bit lvl [3];
    bit inh;
    bit stable;
    bit allDiff;
    bit s;
    int j, expEvents, expRejects;

    reset = 1'b1;
    busA.coinSense5 = 0; busA.coinSense10 = 0; busA.coinSense25 = 0; busA.inhibit = 0;
    busB.coinSense5 = 0; busB.coinSense10 = 0; busB.coinSense25 = 0; busB.inhibit = 0;
    clearCounts();
    repeat (3) step();
    check("reset_outputsA", int'({busA.fiveCents, busA.tenCents, busA.twentyFiveCents,
                                  busA.coinRejected, busA.coinDropped}), 0);
    check("reset_queueA", int'(busA.queueCount), 0);
    check("reset_outputsB", int'({busB.fiveCents, busB.tenCents, busB.twentyFiveCents,
                                  busB.coinRejected, busB.coinDropped}), 0);
    reset = 1'b0;
    repeat (5) step();

    // Bounce on the 5c line, then a clean hold
    clearCounts();
    for (int i = 0; i < 10; i++) begin
      busA.coinSense5 = ~busA.coinSense5;
      repeat (3) step();
    end
    busA.coinSense5 = 1;
    e0 = edgeIdx + 1;
    repeat (40) step();
    check("bounce_count", nA5, 1);
    check("bounce_latency", firstA5 - e0, 20);
    busA.coinSense5 = 0;
    repeat (30) step();

    // Simultaneous coins on all three lines
    clearCounts();
    busA.coinSense5 = 1; busA.coinSense10 = 1; busA.coinSense25 = 1;
    e0 = edgeIdx + 1;
    repeat (40) step();
    check("simul_5_at", firstA5 - e0, 20);
    check("simul_10_at", firstA10 - e0, 22);
    check("simul_25_at", firstA25 - e0, 24);
    check("simul_total", nA5 + nA10 + nA25, 3);
    busA.coinSense5 = 0; busA.coinSense10 = 0; busA.coinSense25 = 0;
    repeat (30) step();

    // Overflow on the shallow instance
    clearCounts();
    for (int k = 0; k < 6; k++) begin
      busB.coinSense5 = 1;
      repeat (3) step();
      busB.coinSense5 = 0;
      repeat (3) step();
    end
    repeat (330) step();
    check("ovf_dropped", nBdrop, 2);
    check("ovf_queue_peak", maxQB, 2);
    check("ovf_pulses", nB5, 4);
    check("ovf_spacing_min", minSpB, 101);
    check("ovf_spacing_max", maxSpB, 101);

    // Inhibit while a 10c coin is in flight
    clearCounts();
    busA.coinSense10 = 1;
    e0 = edgeIdx + 1;
    step();
    busA.coinSense25 = 1;
    repeat (18) step();
    busA.inhibit = 1;
    repeat (30) step();
    check("inh_rejected", nArej, 1);
    check("inh_rejected_at", firstArej - e0, 19);
    check("inh_ten_count", nA10, 1);
    check("inh_ten_at", firstA10 - e0, 20);
    check("inh_no_25", nA25, 0);
    busA.inhibit = 0; busA.coinSense10 = 0; busA.coinSense25 = 0;
    repeat (30) step();

    // Reset in the middle of a burst on the shallow instance
    clearCounts();
    busB.coinSense5 = 1; busB.coinSense10 = 1; busB.coinSense25 = 1;
    repeat (6) step();
    check("rstmid_pulse_before", int'(busB.fiveCents), 1);
    check("rstmid_queue_before", int'(busB.queueCount), 1);
    reset = 1'b1;
    busB.coinSense5 = 0; busB.coinSense10 = 0; busB.coinSense25 = 0;
    #1;
    check("rstmid_outputs", int'({busB.fiveCents, busB.tenCents, busB.twentyFiveCents,
                                  busB.coinRejected, busB.coinDropped}), 0);
    check("rstmid_queue", int'(busB.queueCount), 0);
    repeat (3) step();
    reset = 1'b0;
    clearCounts();
    repeat (200) step();
    check("rstmid_no_pulses", nB, 0);
    check("rstmid_no_pulsesA", nA5 + nA10 + nA25, 0);

    // Random raw stimulus; the debounce reference is a sliding window rule
    clearCounts();
    lvl = '{0, 0, 0};
    inh = 0;
    for (int i = 0; i < RAND_LEN; i++) begin
      if (i < RAND_ACTIVE) begin
        for (int c = 0; c < 3; c++) begin
          if ($urandom_range(9, 0) == 0) lvl[c] = ~lvl[c];
        end
        if ($urandom_range(199, 0) == 0) inh = ~inh;
      end else begin
        lvl = '{0, 0, 0};
        inh = 0;
      end
      busA.coinSense5 = lvl[0]; busA.coinSense10 = lvl[1]; busA.coinSense25 = lvl[2];
      busA.inhibit = inh;
      for (int c = 0; c < 3; c++) rawH[c][i] = lvl[c];
      inhH[i] = inh;
      step();
    end

    // A level is accepted once the twice-delayed raw line has shown the
    // opposite value for DEBOUNCE consecutive samples.
    expEvents = 0;
    expRejects = 0;
    for (int c = 0; c < 3; c++) begin
      stable = 0;
      for (int n = 0; n < RAND_LEN; n++) begin
        allDiff = 1;
        for (int k = 0; k < TB_DEBOUNCE; k++) begin
          j = n - 2 - k;
          s = (j < 0) ? 1'b0 : rawH[c][j];
          if (s == stable) allDiff = 0;
        end
        if (allDiff) begin
          stable = ~stable;
          if (stable) begin
            expEvents++;
            if (n + 1 < RAND_LEN && inhH[n + 1]) expRejects++;
          end
        end
      end
    end
    check("rand_rejected", nArej, expRejects);
    check("rand_conservation", nA5 + nA10 + nA25, expEvents - nArej - nAdrop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
